hlsm_arbiter: RTL and testbench
===============================

Name: hlsm_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one HLSM datapath instance (Start/Done handshake, operands a..e, result i) among NUM_REQ requesters.
- Accepts one job at a time, latches its operands, pulses HLSM Start, waits for Done and returns the result to the owning requester.
- Sits between requesting blocks and the single HLSM instance in the top-level design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATAWIDTH, 16, signed operand/result width.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when HLSM_ARB_TIMEOUT_EN is defined.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- ReqValid  in  NUM_REQ  per-requester job request; held high with data stable until the matching ReqReady bit is seen.
- ReqData  in  NUM_REQ*5*DATAWIDTH  operands for requester k at slice k, packed {a,b,c,d,e}, a in the MSBs.
- ReqReady  out  NUM_REQ  one-hot, one-cycle pulse: job accepted.
- RespValid  out  NUM_REQ  one-hot, one-cycle pulse: result available.
- RespData  out  DATAWIDTH  result; valid only while RespValid is nonzero.
- RespErr  out  1  qualifies RespValid; 1 = timeout.
- HlsmStart  out  1  Start pulse to HLSM.
- HlsmA, HlsmB, HlsmC, HlsmD, HlsmE  out  DATAWIDTH each  HLSM operands.
- HlsmDone  in  1  HLSM Done.
- HlsmI  in  DATAWIDTH  HLSM result i.

Behaviour:
- Reset values: all outputs 0; state IDLE; grant pointer Last = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation returns to IDLE and drops the in-flight job. No RespValid is issued for it. The HLSM shares Rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any ReqValid is high, the winner k is the first set bit searching Last+1, Last+2, ... with wrap-around modulo NUM_REQ.
  - At that edge: latch ReqData slice k into the Hlsm* operand registers, set Last=k, go to ISSUE.
  - If no ReqValid is high, stay in IDLE.
- ISSUE (exactly 1 cycle): HlsmStart=1 and ReqReady[k]=1, then go to WAIT.
- WAIT: HlsmStart=0. On the edge where HlsmDone=1:
  - capture HlsmI into RespData;
  - set RespErr=0;
  - go to RESP.
- RESP (exactly 1 cycle): RespValid[k]=1, then go to IDLE. RespData holds its value until the next capture.
- Hlsm* operand outputs stay stable from capture until the next capture.
- HlsmDone is ignored in IDLE, ISSUE and RESP.
- Latency: with HLSM latency L cycles from Start to Done, the first RespValid appears L+3 cycles after the edge at which ReqValid is sampled.
- Back-to-back throughput: one job per L+4 cycles.
- Requests arriving during ISSUE, WAIT or RESP wait. They are arbitrated at the next IDLE edge and are never lost while ReqValid is held.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,...,NUM_REQ-1,0,...
- No arithmetic is done in this block; data passes through unmodified at signed DATAWIDTH.

Optional Feature:
- Macro: HLSM_ARB_TIMEOUT_EN.
- When defined:
  - A WAIT-cycle counter resets on entry to WAIT.
  - If the counter reaches TIMEOUT_CYCLES without HlsmDone, go to RESP with RespData=0 and RespErr=1.
  - Done arriving on that same edge wins, so the response is a normal result.
  - A late Done arriving after the timeout is ignored.
- When not defined: no counter is built, RespErr is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single request: requester 2 presents a=1, b=2, c=3, d=4, e=5 with a behavioural HLSM (L=4, i=a+b+c+d+e). Required response:
  - ReqReady[2] pulses once;
  - HlsmStart is high for exactly one cycle with those operands;
  - RespValid=4'b0100 and RespData=15 arrive 7 cycles after the request edge.
- Simultaneous requests 0 and 3 from reset: requester 0 is served first and requester 3 second. Each gets its own correct result, and the two RespValid pulses are 8 cycles apart.
- Continuous requests from all 4 requesters for 12 jobs: grant order is 0,1,2,3 repeated 3 times, with no duplicate or missing responses.
- Rst asserted for 1 cycle mid-WAIT: all outputs go to 0 and no RespValid is issued for the aborted job. A new request afterward completes normally.
- Spurious HlsmDone in IDLE, and HlsmDone held during ISSUE: no RespValid and no state change.
- With HLSM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10 and an HLSM that never returns Done: RespValid plus RespErr=1 and RespData=0 appear after 10 WAIT cycles. A late Done is ignored.

Source files
------------

// File: rtl/hlsm_arbiter.sv
// hlsm_arbiter: round-robin sharing of one HLSM datapath among NUM_REQ requesters.
// Optional WAIT-state timeout is built when HLSM_ARB_TIMEOUT_EN is defined.

module hlsm_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATAWIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             ReqValid,
    input  logic [NUM_REQ*5*DATAWIDTH-1:0] ReqData,
    output logic [NUM_REQ-1:0]             ReqReady,
    output logic [NUM_REQ-1:0]             RespValid,
    output logic signed [DATAWIDTH-1:0]    RespData,
    output logic                           RespErr,
    output logic                           HlsmStart,
    output logic signed [DATAWIDTH-1:0]    HlsmA,
    output logic signed [DATAWIDTH-1:0]    HlsmB,
    output logic signed [DATAWIDTH-1:0]    HlsmC,
    output logic signed [DATAWIDTH-1:0]    HlsmD,
    output logic signed [DATAWIDTH-1:0]    HlsmE,
    input  logic                           HlsmDone,
    input  logic signed [DATAWIDTH-1:0]    HlsmI
);

    localparam int LW = $clog2(NUM_REQ);
    localparam int JW = 5 * DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LW-1:0]      last;
    logic [LW-1:0]      winner;
    logic               found;
    logic [JW-1:0]      job;
    logic [NUM_REQ-1:0] grant;
    logic               tmo_hit;

    // Reject unsupported configurations at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("hlsm_arbiter: parameter out of range");
    end

    // Rotating-priority search starting just after the last grant
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = last;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && ReqValid[LW'(idx)]) begin
                found  = 1'b1;
                winner = LW'(idx);
            end
        end
    end

    // Select the operand slice of the winning requester
    always_comb begin
        job = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == LW'(k)) begin
                job = ReqData[k*JW +: JW];
            end
        end
    end

    assign grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << last;

    // Next-state and handshake outputs decoded from the current state
    always_comb begin
        state_nxt = state;
        HlsmStart = 1'b0;
        ReqReady  = '0;
        RespValid = '0;
        unique case (state)
            IDLE: begin
                if (found) state_nxt = ISSUE;
            end
            ISSUE: begin
                HlsmStart = 1'b1;
                ReqReady  = grant;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (HlsmDone || tmo_hit) state_nxt = RESP;
            end
            RESP: begin
                RespValid = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant pointer, operand latch and result capture
    always_ff @(posedge Clk) begin
        if (Rst) begin
            last     <= LW'(NUM_REQ - 1);
            HlsmA    <= '0;
            HlsmB    <= '0;
            HlsmC    <= '0;
            HlsmD    <= '0;
            HlsmE    <= '0;
            RespData <= '0;
        end else begin
            if (state == IDLE && found) begin
                last <= winner;
                {HlsmA, HlsmB, HlsmC, HlsmD, HlsmE} <= job;
            end
            if (state == WAIT && HlsmDone) begin
                RespData <= HlsmI;
            end else if (tmo_hit) begin
                RespData <= '0;
            end
        end
    end

`ifdef HLSM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // Done on the final WAIT cycle beats the timeout
    assign tmo_hit = (state == WAIT) && !HlsmDone &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter, cleared while issuing so each job starts at zero
    always_ff @(posedge Clk) begin
        if (Rst)                 wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + CW'(1);
    end

    // Error flag records how the most recent WAIT ended
    always_ff @(posedge Clk) begin
        if (Rst)                            err_q <= 1'b0;
        else if (state == WAIT && HlsmDone) err_q <= 1'b0;
        else if (tmo_hit)                   err_q <= 1'b1;
    end

    assign RespErr = err_q;
`else
    assign tmo_hit = 1'b0;
    assign RespErr = 1'b0;
`endif

endmodule

// File: tb/tb_hlsm_arbiter.sv
// tb_hlsm_arbiter: directed scoreboard bench for hlsm_arbiter with a behavioural HLSM.
// Timeout scenario runs only when HLSM_ARB_TIMEOUT_EN is defined.

module tb_hlsm_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int JW  = 5 * DW;
    localparam int LAT = 4;
    localparam int TMO = 10;

    typedef struct {
        int                    req;
        logic signed [DW-1:0]  data;
        logic                  err;
    } exp_t;

    logic                  Clk = 1'b0;
    logic                  Rst;
    logic [NR-1:0]         ReqValid;
    logic [NR*JW-1:0]      ReqData;
    logic [NR-1:0]         ReqReady;
    logic [NR-1:0]         RespValid;
    logic signed [DW-1:0]  RespData;
    logic                  RespErr;
    logic                  HlsmStart;
    logic signed [DW-1:0]  HlsmA, HlsmB, HlsmC, HlsmD, HlsmE;
    logic                  HlsmDone;
    logic signed [DW-1:0]  HlsmI;

    logic                  m_busy;
    logic                  m_done;
    logic                  m_never;
    logic [2:0]            m_cnt;
    logic signed [DW-1:0]  m_res;
    logic                  spur;

    exp_t                  sb[$];
    logic [JW-1:0]         st_q[$];
    int                    resp_edge[$];
    logic [JW-1:0]         job_tab[NR][3];
    int                    pos[NR];
    int                    njobs[NR];
    int                    n_acc[NR];
    int                    n_start;
    int                    n_assert;
    int                    n_fail;
    int                    cyc;
    int                    cr;
    int                    a0;
    int                    s0;

    hlsm_arbiter #(
        .NUM_REQ       (NR),
        .DATAWIDTH     (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .ReqValid (ReqValid),
        .ReqData  (ReqData),
        .ReqReady (ReqReady),
        .RespValid(RespValid),
        .RespData (RespData),
        .RespErr  (RespErr),
        .HlsmStart(HlsmStart),
        .HlsmA    (HlsmA),
        .HlsmB    (HlsmB),
        .HlsmC    (HlsmC),
        .HlsmD    (HlsmD),
        .HlsmE    (HlsmE),
        .HlsmDone (HlsmDone),
        .HlsmI    (HlsmI)
    );

    always #5 Clk = ~Clk;

    // Behavioural HLSM: samples Start, raises Done for one cycle LAT edges later
    always @(posedge Clk) begin
        if (Rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= '0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && HlsmStart) begin
                m_busy <= 1'b1;
                m_cnt  <= 3'(LAT - 1);
                m_res  <= HlsmA + HlsmB + HlsmC + HlsmD + HlsmE;
            end else if (m_busy) begin
                if (m_cnt == 3'd0) begin
                    m_busy <= 1'b0;
                    m_done <= !m_never;
                end else begin
                    m_cnt <= m_cnt - 3'd1;
                end
            end
        end
    end

    assign HlsmDone = m_done | spur;
    assign HlsmI    = m_res;

    function automatic logic [JW-1:0] mk(input int a, input int b, input int c,
                                         input int d, input int e);
        return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e)};
    endfunction

    function automatic logic signed [DW-1:0] hsum(input logic [JW-1:0] j);
        return j[4*DW +: DW] + j[3*DW +: DW] + j[2*DW +: DW] +
               j[DW +: DW] + j[0 +: DW];
    endfunction

    task automatic chk(input string tag, input logic [JW-1:0] obs,
                       input logic [JW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, JW'(ReqReady), '0);
        chk({tag, "_rvalid"}, JW'(RespValid), '0);
        chk({tag, "_rdata"}, JW'(RespData), '0);
        chk({tag, "_rerr"}, JW'(RespErr), '0);
        chk({tag, "_start"}, JW'(HlsmStart), '0);
        chk({tag, "_ops"}, {HlsmA, HlsmB, HlsmC, HlsmD, HlsmE}, '0);
    endtask

    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        if (st_q.size() == 0) begin
            chk("start_unexpected", JW'(HlsmStart), '0);
        end else if (HlsmStart) begin
            n_start++;
            chk("start_ops", {HlsmA, HlsmB, HlsmC, HlsmD, HlsmE}, st_q.pop_front());
        end
        if (sb.size() == 0) begin
            chk("resp_unexpected", JW'(RespValid), '0);
        end else if (RespValid != '0) begin
            e = sb.pop_front();
            chk($sformatf("resp_valid_req%0d", e.req), JW'(RespValid),
                JW'(NR'(1) << e.req));
            chk("resp_data", JW'(RespData), JW'(e.data));
            chk("resp_err", JW'(RespErr), JW'(e.err));
            resp_edge.push_back(cyc + 1);
        end
        for (int k = 0; k < NR; k++) begin
            if (ReqReady[k]) begin
                n_acc[k]++;
                pos[k]++;
                if (pos[k] < njobs[k]) ReqData[k*JW +: JW] = job_tab[k][pos[k]];
                else                   ReqValid[k] = 1'b0;
            end
        end
    endtask

    task automatic present(input int k, input int n);
        njobs[k] = n;
        pos[k]   = 0;
        ReqData[k*JW +: JW] = job_tab[k][0];
        ReqValid[k] = 1'b1;
    endtask

    task automatic expect_job(input int k, input logic [JW-1:0] j,
                              input logic signed [DW-1:0] d, input logic err);
        exp_t e;
        e.req  = k;
        e.data = d;
        e.err  = err;
        sb.push_back(e);
        st_q.push_back(j);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb.size() > 0; i++) step();
        chk("drain_timeout", JW'(sb.size()), '0);
        step();
    endtask

    task automatic do_reset();
        ReqValid = '0;
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        n_start  = 0;
        spur     = 1'b0;
        m_never  = 1'b0;
        Rst      = 1'b1;
        ReqValid = '0;
        ReqData  = '0;
        for (int k = 0; k < NR; k++) begin
            pos[k]   = 0;
            njobs[k] = 0;
            n_acc[k] = 0;
        end

        // Reset state
        step();
        step();
        chk_all_zero("reset");
        Rst = 1'b0;
        step();

        // Single request from requester 2
        job_tab[2][0] = mk(1, 2, 3, 4, 5);
        expect_job(2, job_tab[2][0], 16'sd15, 1'b0);
        s0 = n_start;
        resp_edge.delete();
        cr = cyc + 1;
        present(2, 1);
        drain(30);
        chk("single_ready_cnt", JW'(n_acc[2]), JW'(1));
        chk("single_start_cnt", JW'(n_start - s0), JW'(1));
        chk("single_latency", JW'(resp_edge[0] - cr), JW'(LAT + 3));

        // Simultaneous requests 0 and 3 from reset
        do_reset();
        job_tab[0][0] = mk(10, -20, 30, -40, 50);
        job_tab[3][0] = mk(-1, -2, -3, -4, -5);
        expect_job(0, job_tab[0][0], hsum(job_tab[0][0]), 1'b0);
        expect_job(3, job_tab[3][0], hsum(job_tab[3][0]), 1'b0);
        resp_edge.delete();
        cr = cyc + 1;
        present(0, 1);
        present(3, 1);
        drain(40);
        chk("pair_first_latency", JW'(resp_edge[0] - cr), JW'(LAT + 3));
        chk("pair_spacing", JW'(resp_edge[1] - resp_edge[0]), JW'(LAT + 4));

        // Continuous requests from all four, three jobs each
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < NR; k++) begin
                job_tab[k][n] = mk(100 * k + n, n, -k, 7, 1000 * n);
            end
        end
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < NR; k++) begin
                expect_job(k, job_tab[k][n], hsum(job_tab[k][n]), 1'b0);
            end
        end
        for (int k = 0; k < NR; k++) present(k, 3);
        drain(12 * (LAT + 4) + 20);
        chk("rr_valid_dropped", JW'(ReqValid), '0);

        // Reset in the middle of WAIT drops the job
        job_tab[1][0] = mk(9, 9, 9, 9, 9);
        st_q.push_back(job_tab[1][0]);
        a0 = n_acc[1];
        present(1, 1);
        for (int i = 0; i < 10 && n_acc[1] == a0; i++) step();
        chk("abort_accept", JW'(n_acc[1]), JW'(a0 + 1));
        step();
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk_all_zero("midwait_reset");
        for (int i = 0; i < 12; i++) step();
        job_tab[1][0] = mk(1, 1, 1, 1, 32767);
        expect_job(1, job_tab[1][0], hsum(job_tab[1][0]), 1'b0);
        resp_edge.delete();
        cr = cyc + 1;
        present(1, 1);
        drain(30);
        chk("post_reset_latency", JW'(resp_edge[0] - cr), JW'(LAT + 3));

        // Spurious Done in IDLE, then Done held through ISSUE
        spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_done_ready", JW'(ReqReady), '0);
        end
        job_tab[0][0] = mk(3, 0, 0, 0, -8);
        expect_job(0, job_tab[0][0], hsum(job_tab[0][0]), 1'b0);
        resp_edge.delete();
        cr = cyc + 1;
        present(0, 1);
        step();
        chk("issue_start", JW'(HlsmStart), JW'(1));
        step();
        spur = 1'b0;
        chk("after_issue_start", JW'(HlsmStart), '0);
        chk("after_issue_resp", JW'(RespValid), '0);
        drain(30);
        chk("spur_latency", JW'(resp_edge[0] - cr), JW'(LAT + 3));

`ifdef HLSM_ARB_TIMEOUT_EN
        // HLSM never answers: timeout response, late Done ignored
        m_never = 1'b1;
        job_tab[2][0] = mk(5, 5, 5, 5, 5);
        expect_job(2, job_tab[2][0], '0, 1'b1);
        resp_edge.delete();
        cr = cyc + 1;
        present(2, 1);
        drain(TMO + 20);
        chk("timeout_latency", JW'(resp_edge[0] - cr), JW'(TMO + 2));
        m_never = 1'b0;
        spur = 1'b1;
        for (int i = 0; i < 3; i++) step();
        spur = 1'b0;
        step();
        job_tab[1][0] = mk(2, 2, 2, 2, 2);
        expect_job(1, job_tab[1][0], 16'sd10, 1'b0);
        present(1, 1);
        drain(30);
`endif

        chk("start_queue_empty", JW'(st_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
